serial_mem_master: RTL and testbench
====================================

Name: serial_mem_master

Overview:
- Host-side initiator for the byte-serial memory-access protocol: turns a local read/write request into the serial command byte stream, then collects the target's response.
- Sits between a local requester (test controller, boot loader) and the serial TX/RX byte engines.
- Protocol: write = 0x00, A[7:0], A[15:8], A[23:16], D[7:0], D[15:8], then ack byte ACK_BYTE back. Read = 0x01, A[7:0], A[15:8], A[23:16], then D[7:0], D[15:8] back.

Parameters:
- ADDR_WIDTH, 24, request address width; only 24 is supported (3 address bytes, LSB first).
- DATA_WIDTH, 16, data width; only 16 is supported (2 data bytes, LSB first).
- ACK_BYTE, 8'd69, byte expected in reply to a write.
- TIMEOUT_CYCLES, 1000000, response watchdog limit (used only with RESP_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; the block uses one clock only.
- rst  in  1  reset; synchronous and active-high.
- req_w_en  in  1  write request strobe, sampled only when req_rdy=1.
- req_r_en  in  1  read request strobe; if req_w_en is also high in the same cycle, the write wins.
- req_addr  in  ADDR_WIDTH  request address, captured with the strobe.
- req_data_in  in  DATA_WIDTH  write data, captured with the strobe.
- req_rdy  out  1  block idle and accepting a request.
- req_cplt  out  1  one-cycle completion pulse.
- req_data_out  out  DATA_WIDTH  read data; valid while req_cplt=1 and held until the next read completes.
- req_err  out  1  high together with req_cplt when the transaction failed.
- serial_out_rdy  in  1  TX engine can accept a byte.
- serial_out_en  out  1  one-cycle TX byte strobe.
- serial_data_out  out  8  TX byte.
- serial_in_cplt  in  1  RX byte valid strobe.
- serial_data_in  in  8  RX byte.
- serial_in_error  in  1  RX framing error strobe.

Behaviour:
- Reset values: req_rdy=1, req_cplt=0, req_err=0, req_data_out=0, serial_out_en=0, serial_data_out=0, state=IDLE, byte counter=0.
- A reset in the middle of a transaction aborts it immediately. No completion pulse is produced.
- State IDLE:
  - req_rdy=1.
  - On a strobe, capture the address, data and op into a TX buffer, drop req_rdy on the next cycle, go to SEND.
  - RX bytes arriving in IDLE are discarded.
- State SEND:
  - Byte counter idx runs 0..5 for a write and 0..3 for a read.
  - When serial_out_rdy=1 and serial_out_en=0: drive serial_data_out=byte[idx], pulse serial_out_en, then idx++.
  - serial_out_en is never high on two consecutive cycles. The TX engine must drop serial_out_rdy the cycle after it samples serial_out_en.
  - After the last byte is sent, clear the RX counter and go to RECV.
- State RECV: each serial_in_cplt stores one byte.
  - Write: one byte expected. If it equals ACK_BYTE, err=0; otherwise err=1. Go to DONE.
  - Read: first byte goes to rd[7:0], second to rd[15:8]. After the second byte, go to DONE with err=0.
  - serial_in_error in RECV: err=1, go to DONE immediately.
  - If serial_in_error and serial_in_cplt are both high in the same cycle, the error wins.
- State DONE (one cycle):
  - req_cplt=1 and req_err=err.
  - On a successful read, req_data_out is updated to rd. On a failed read, req_data_out keeps its previous value.
  - Next cycle: return to IDLE with req_rdy=1.
- Latency:
  - Minimum request-to-cplt is 2*N_tx + N_rx + 2 cycles with an always-ready TX and zero-latency replies, where N_tx = 6 (write) or 4 (read) and N_rx = 1 (write) or 2 (read).
  - A back-to-back request can be accepted on the cycle req_rdy returns.

Optional Feature:
- Macro SERIAL_MEM_MASTER_RESP_TIMEOUT_EN.
- Defined:
  - A counter counts RECV cycles and is cleared on each received byte.
  - When it reaches TIMEOUT_CYCLES: go to DONE with req_err=1.
  - The counter is reset by rst and on entry to RECV.
- Undefined: no counter is built. RECV waits indefinitely.

Decomposition:
- Package serial_mem_pkg:
  - CMD_WRITE=8'h00, CMD_READ=8'h01, ACK_BYTE default.
  - State enum: IDLE, SEND, RECV, DONE.
  - Byte-count constants: WR_TX=6, RD_TX=4, WR_RX=1, RD_RX=2.
  - Shared with the target-side command decoder.
- Sub-module serial_byte_sender: byte-buffer index plus the rdy/en strobe handshake.

Test Plan:
- Write addr 0x123456, data 0xBEEF, TX always ready, reply 0x45 -> TX bytes 00 56 34 12 EF BE; req_cplt=1, req_err=0.
- Read addr 0x00A0FF, reply 0x34 then 0x12 -> TX bytes 01 FF A0 00; req_data_out=0x1234 with req_cplt, req_err=0.
- Write with reply 0x00 -> req_err=1 with req_cplt. Read with serial_in_error after the first reply byte -> req_err=1, req_data_out unchanged.
- TX stalled (serial_out_rdy=0 for 20 cycles between bytes), plus req_w_en and req_r_en asserted together -> byte order intact, no double strobe, write op chosen; rst=1 mid-SEND -> req_rdy=1 and serial_out_en=0 on the next cycle.
- With SERIAL_MEM_MASTER_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=50, read with no reply -> req_cplt with req_err=1 exactly 50 cycles after RECV entry; without the macro, still waiting at 1000 cycles.

Source files
------------

// File: rtl/serial_mem_pkg.sv
// Shared definitions for the byte-serial memory-access protocol.
// Used by the host-side master and the target-side command decoder.
package serial_mem_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h00;
    localparam logic [7:0] CMD_READ     = 8'h01;
    localparam logic [7:0] ACK_BYTE_DEF = 8'd69;

    // Bytes on the wire per operation: command + 3 address (+ 2 data for writes)
    localparam logic [2:0] WR_TX = 3'd6;
    localparam logic [2:0] RD_TX = 3'd4;
    localparam logic [1:0] WR_RX = 2'd1;
    localparam logic [1:0] RD_RX = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } sm_state_e;

endpackage

// File: rtl/serial_byte_sender.sv
// Walks a 6-byte TX buffer (byte 0 in bits [7:0]) and hands bytes to the TX
// engine one at a time. A byte is issued only when the engine is ready and no
// strobe went out in the previous cycle, so serial_out_en never stays high for
// two consecutive cycles.
module serial_byte_sender (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        active,
    input  logic [2:0]  n_bytes,
    input  logic [47:0] tx_buf,
    input  logic        serial_out_rdy,
    output logic        serial_out_en,
    output logic [7:0]  serial_data_out,
    output logic        done
);

    logic [2:0] idx_q, idx_d;
    logic       en_q, en_d;
    logic [7:0] data_q, data_d;
    logic [7:0] cur_byte;

    // Select the byte addressed by the current index
    always_comb begin
        cur_byte = tx_buf[7:0];
        case (idx_q)
            3'd1:    cur_byte = tx_buf[15:8];
            3'd2:    cur_byte = tx_buf[23:16];
            3'd3:    cur_byte = tx_buf[31:24];
            3'd4:    cur_byte = tx_buf[39:32];
            3'd5:    cur_byte = tx_buf[47:40];
            default: cur_byte = tx_buf[7:0];
        endcase
    end

    // Issue the next byte when the engine is ready and no strobe is in flight
    always_comb begin
        idx_d  = idx_q;
        en_d   = 1'b0;
        data_d = data_q;
        if (start) begin
            idx_d = 3'd0;
        end else if (active && (idx_q != n_bytes) && serial_out_rdy && !en_q) begin
            en_d   = 1'b1;
            data_d = cur_byte;
            idx_d  = idx_q + 3'd1;
        end
    end

    // Index, strobe and byte registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 3'd0;
            en_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            idx_q  <= idx_d;
            en_q   <= en_d;
            data_q <= data_d;
        end
    end

    // Finished once every byte is out and the last strobe has retired
    assign done            = active && (idx_q == n_bytes) && !en_q;
    assign serial_out_en   = en_q;
    assign serial_data_out = data_q;

endmodule

// File: rtl/serial_mem_master.sv
// Host-side initiator for the byte-serial memory-access protocol.
// Optional response watchdog: define SERIAL_MEM_MASTER_RESP_TIMEOUT_EN to build
// a RECV timeout of TIMEOUT_CYCLES cycles; without it RECV waits indefinitely.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | req_rdy high, waiting for a request strobe; RX bytes ignored
// SEND  | streaming command/address/data bytes to the TX engine
// RECV  | collecting the ack byte (write) or two data bytes (read)
// DONE  | one-cycle completion pulse with error flag and read data
module serial_mem_master
    import serial_mem_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 24,
    parameter int         DATA_WIDTH     = 16,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_w_en,
    input  logic                  req_r_en,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data_in,
    output logic                  req_rdy,
    output logic                  req_cplt,
    output logic [DATA_WIDTH-1:0] req_data_out,
    output logic                  req_err,
    input  logic                  serial_out_rdy,
    output logic                  serial_out_en,
    output logic [7:0]            serial_data_out,
    input  logic                  serial_in_cplt,
    input  logic [7:0]            serial_data_in,
    input  logic                  serial_in_error
);

    sm_state_e             state_q, state_d;
    logic                  op_wr_q, op_wr_d;
    logic [47:0]           tx_buf_q, tx_buf_d;
    logic [1:0]            rx_cnt_q, rx_cnt_d;
    logic [7:0]            rd_lo_q, rd_lo_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic                  start;
    logic                  send_done;
    logic                  resp_timeout;
    logic [2:0]            n_tx;
    logic [1:0]            n_rx;

    assign n_tx = op_wr_q ? WR_TX : RD_TX;
    assign n_rx = op_wr_q ? WR_RX : RD_RX;

    serial_byte_sender u_sender (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .active          (state_q == SEND),
        .n_bytes         (n_tx),
        .tx_buf          (tx_buf_q),
        .serial_out_rdy  (serial_out_rdy),
        .serial_out_en   (serial_out_en),
        .serial_data_out (serial_data_out),
        .done            (send_done)
    );

`ifdef SERIAL_MEM_MASTER_RESP_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Down-counter: held at the load value outside RECV, reloaded on every
    // received byte, terminal count means the target went silent
    always_comb begin
        tmr_d = tmr_q;
        if ((state_q != RECV) || serial_in_cplt) begin
            tmr_d = TMR_LOAD;
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
        end
    end

    // Watchdog register
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= TMR_LOAD;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign resp_timeout = (state_q == RECV) && (tmr_q == '0);
`else
    logic unused_tmo;
    assign unused_tmo   = (TIMEOUT_CYCLES == 0);
    assign resp_timeout = 1'b0;
`endif

    // Next-state and datapath updates for the request/response sequence
    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        tx_buf_d   = tx_buf_q;
        rx_cnt_d   = rx_cnt_q;
        rd_lo_d    = rd_lo_q;
        err_d      = err_q;
        data_out_d = data_out_q;
        start      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_w_en || req_r_en) begin
                    // Write wins when both strobes arrive together
                    op_wr_d  = req_w_en;
                    tx_buf_d = {req_data_in, req_addr, (req_w_en ? CMD_WRITE : CMD_READ)};
                    err_d    = 1'b0;
                    start    = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (send_done) begin
                    rx_cnt_d = 2'd0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (serial_in_error) begin
                    // A framing error beats a byte arriving in the same cycle
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (serial_in_cplt) begin
                    rx_cnt_d = rx_cnt_q + 2'd1;
                    if (op_wr_q) begin
                        err_d = (serial_data_in != ACK_BYTE);
                    end else if (rx_cnt_q == 2'd0) begin
                        rd_lo_d = serial_data_in;
                    end
                    if (rx_cnt_d == n_rx) begin
                        state_d = DONE;
                        // Read data is published only on success so a failed read
                        // leaves the previous value visible
                        if (!op_wr_q) begin
                            data_out_d = {serial_data_in, rd_lo_q};
                        end
                    end
                end else if (resp_timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_wr_q    <= 1'b0;
            tx_buf_q   <= '0;
            rx_cnt_q   <= 2'd0;
            rd_lo_q    <= 8'h00;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            tx_buf_q   <= tx_buf_d;
            rx_cnt_q   <= rx_cnt_d;
            rd_lo_q    <= rd_lo_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    assign req_rdy      = (state_q == IDLE);
    assign req_cplt     = (state_q == DONE);
    assign req_err      = (state_q == DONE) && err_q;
    assign req_data_out = data_out_q;

endmodule

// File: tb/tb_serial_mem_master.sv
// Self-checking bench for serial_mem_master: directed protocol cases plus
// randomized transactions against a transaction-level reference model.
module tb_serial_mem_master;

`ifdef SERIAL_MEM_MASTER_RESP_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 1000000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_w_en = 1'b0;
    logic        req_r_en = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_data_in = '0;
    logic        req_rdy;
    logic        req_cplt;
    logic [15:0] req_data_out;
    logic        req_err;
    logic        serial_out_rdy;
    logic        serial_out_en;
    logic [7:0]  serial_data_out;
    logic        serial_in_cplt = 1'b0;
    logic [7:0]  serial_data_in = '0;
    logic        serial_in_error = 1'b0;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          dbl_cnt = 0;
    bit          prev_en = 1'b0;
    int          stall_mode = 0;
    logic [7:0]  tx_q[$];
    logic [15:0] exp_rd = 16'h0000;

    serial_mem_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_w_en        (req_w_en),
        .req_r_en        (req_r_en),
        .req_addr        (req_addr),
        .req_data_in     (req_data_in),
        .req_rdy         (req_rdy),
        .req_cplt        (req_cplt),
        .req_data_out    (req_data_out),
        .req_err         (req_err),
        .serial_out_rdy  (serial_out_rdy),
        .serial_out_en   (serial_out_en),
        .serial_data_out (serial_data_out),
        .serial_in_cplt  (serial_in_cplt),
        .serial_data_in  (serial_data_in),
        .serial_in_error (serial_in_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TX engine capture: record every strobed byte and any back-to-back strobe
    always @(negedge clk) begin
        if (serial_out_en) begin
            tx_q.push_back(serial_data_out);
            if (prev_en) dbl_cnt++;
        end
        prev_en = serial_out_en;
    end

    // TX engine readiness: always ready, fixed 20-cycle stall, or random stall
    initial begin : tx_ready_model
        int gap;
        gap = 0;
        serial_out_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_mode == 0) gap = 0;
            else if (serial_out_en) gap = (stall_mode == 1) ? 20 : int'($urandom_range(0, 4));
            else if (gap > 0) gap--;
            serial_out_rdy = (gap == 0) && !((stall_mode != 0) && serial_out_en);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full transaction; err_at = reply slot replaced by a framing error (-1: none)
    task automatic run_txn(input bit w_en, input bit r_en, input logic [23:0] addr,
                           input logic [15:0] wdata, input logic [7:0] b0, input logic [7:0] b1,
                           input int err_at, input bit err_cplt, input int rx_gap, input bit chk_lat);
        bit         is_wr;
        bit         exp_err;
        logic [7:0] exp_tx[$];
        logic [7:0] rb[2];
        int         n_rx;
        int         t0;
        int         t_c;
        int         guard;

        is_wr = w_en;
        exp_tx.push_back(is_wr ? 8'h00 : 8'h01);
        exp_tx.push_back(addr[7:0]);
        exp_tx.push_back(addr[15:8]);
        exp_tx.push_back(addr[23:16]);
        if (is_wr) begin
            exp_tx.push_back(wdata[7:0]);
            exp_tx.push_back(wdata[15:8]);
        end
        n_rx  = is_wr ? 1 : 2;
        rb[0] = b0;
        rb[1] = b1;
        if (err_at >= 0) exp_err = 1'b1;
        else if (is_wr)  exp_err = (b0 != 8'h45);
        else             exp_err = 1'b0;

        @(negedge clk);
        guard = 0;
        while (!req_rdy && guard < 50) begin @(negedge clk); guard++; end
        chk("rdy_before_req", req_rdy, 1);
        tx_q.delete();
        dbl_cnt     = 0;
        req_w_en    = w_en;
        req_r_en    = r_en;
        req_addr    = addr;
        req_data_in = wdata;
        t0 = cyc;
        @(posedge clk); #1;
        req_w_en = 1'b0;
        req_r_en = 1'b0;
        chk("rdy_drop", req_rdy, 0);

        guard = 0;
        while (tx_q.size() < exp_tx.size() && guard < 3000) begin @(negedge clk); #1; guard++; end
        chk("tx_count", tx_q.size(), exp_tx.size());

        // First RECV cycle starts two edges after the last strobe is seen
        @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < n_rx; i++) begin
            if (i == err_at) begin
                serial_in_error = 1'b1;
                serial_in_cplt  = err_cplt;
                serial_data_in  = is_wr ? 8'h45 : rb[i];
            end else begin
                serial_in_cplt = 1'b1;
                serial_data_in = rb[i];
            end
            @(posedge clk); #1;
            serial_in_error = 1'b0;
            serial_in_cplt  = 1'b0;
            if (i == err_at) break;
            if (i < n_rx - 1) repeat (rx_gap) begin @(posedge clk); #1; end
        end
        if (!is_wr && err_at < 0) exp_rd = {b1, b0};

        guard = 0;
        while (!req_cplt && guard < 200) begin @(negedge clk); guard++; end
        t_c = cyc;
        chk("cplt_seen", req_cplt, 1);
        chk("req_err", req_err, exp_err);
        chk("data_out", req_data_out, exp_rd);
        chk("tx_count_final", tx_q.size(), exp_tx.size());
        chk("double_strobe", dbl_cnt, 0);
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) chk("tx_byte", tx_q[i], exp_tx[i]);
        if (chk_lat) chk("latency", t_c - t0, 2 * exp_tx.size() + n_rx + 2);
        @(posedge clk); #1;
        chk("cplt_one_cycle", req_cplt, 0);
        chk("rdy_back", req_rdy, 1);
    endtask

    initial begin : main
        int guard;
        int n_c;
        int t_last;
        bit w;
        bit r;
        int ea;
        int gap;
        logic [7:0] b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", req_rdy, 1);
        chk("rst_cplt", req_cplt, 0);
        chk("rst_err", req_err, 0);
        chk("rst_data_out", req_data_out, 0);
        chk("rst_out_en", serial_out_en, 0);
        chk("rst_out_data", serial_data_out, 0);
        rst = 1'b0;

        // Directed protocol cases
        run_txn(1, 0, 24'h123456, 16'hBEEF, 8'h45, 8'h00, -1, 0, 0, 1);
        run_txn(0, 1, 24'h00A0FF, 16'h0000, 8'h34, 8'h12, -1, 0, 0, 1);
        run_txn(1, 0, 24'h000010, 16'h5555, 8'h00, 8'h00, -1, 0, 0, 1);
        run_txn(0, 1, 24'h000020, 16'h0000, 8'h99, 8'h88, 1, 0, 0, 0);
        run_txn(1, 0, 24'hABCDEF, 16'h1357, 8'h45, 8'h00, 0, 1, 0, 0);
        run_txn(0, 1, 24'h0000F0, 16'h0000, 8'h77, 8'h66, 1, 1, 0, 0);

        // Stray RX traffic while idle must not disturb the next read
        @(negedge clk);
        serial_in_cplt = 1'b1;
        serial_data_in = 8'hAA;
        @(posedge clk); #1;
        serial_in_cplt  = 1'b0;
        serial_in_error = 1'b1;
        @(posedge clk); #1;
        serial_in_error = 1'b0;
        run_txn(0, 1, 24'h5A5A5A, 16'h0000, 8'h5A, 8'hC3, -1, 0, 1, 0);

        // Stalled TX engine with both strobes: write must win, order intact
        stall_mode = 1;
        run_txn(1, 1, 24'hFEDCBA, 16'hCAFE, 8'h45, 8'h00, -1, 0, 0, 0);

        // Reset in the middle of SEND
        tx_q.delete();
        @(negedge clk);
        req_w_en    = 1'b1;
        req_addr    = 24'h010203;
        req_data_in = 16'h0405;
        @(posedge clk); #1;
        req_w_en = 1'b0;
        guard = 0;
        while (tx_q.size() < 2 && guard < 200) begin @(negedge clk); #1; guard++; end
        chk("midsend_progress", tx_q.size(), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rdy", req_rdy, 1);
        chk("midrst_out_en", serial_out_en, 0);
        chk("midrst_cplt", req_cplt, 0);
        rst = 1'b0;
        stall_mode = 0;
        exp_rd = 16'h0000;
        chk("midrst_data_out", req_data_out, exp_rd);
        n_c = 0;
        repeat (10) begin @(negedge clk); if (req_cplt) n_c++; end
        chk("midrst_no_cplt", n_c, 0);

        // Read with no reply at all
        tx_q.delete();
        @(negedge clk);
        req_r_en = 1'b1;
        req_addr = 24'h000777;
        @(posedge clk); #1;
        req_r_en = 1'b0;
        guard = 0;
        while (tx_q.size() < 4 && guard < 100) begin @(negedge clk); #1; guard++; end
        chk("noreply_tx_count", tx_q.size(), 4);
        t_last = cyc;
`ifdef SERIAL_MEM_MASTER_RESP_TIMEOUT_EN
        guard = 0;
        while (!req_cplt && guard < TMO + 50) begin @(negedge clk); guard++; end
        chk("tmo_cplt", req_cplt, 1);
        chk("tmo_delay", cyc - t_last, TMO + 2);
        chk("tmo_err", req_err, 1);
        chk("tmo_data_out", req_data_out, exp_rd);
        @(posedge clk); #1;
        chk("tmo_rdy_back", req_rdy, 1);
`else
        n_c = 0;
        repeat (1000) begin @(negedge clk); if (req_cplt) n_c++; end
        chk("wait_no_cplt", n_c, 0);
        chk("wait_still_busy", req_rdy, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd = 16'h0000;
        chk("wait_rst_rdy", req_rdy, 1);
`endif

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            w  = $urandom_range(0, 1);
            r  = w ? bit'($urandom_range(0, 1)) : 1'b1;
            b0 = ($urandom_range(0, 1) == 1) ? 8'h45 : 8'($urandom);
            ea = -1;
            if ($urandom_range(0, 4) == 0) ea = w ? 0 : int'($urandom_range(0, 1));
            gap = $urandom_range(0, 3);
            stall_mode = ($urandom_range(0, 5) == 0) ? 1 : int'($urandom_range(0, 1)) * 2;
            run_txn(w, r, 24'($urandom), 16'($urandom), b0, 8'($urandom), ea,
                    bit'($urandom_range(0, 1)), gap, (stall_mode == 0) && (gap == 0) && (ea < 0));
        end
        stall_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
